// File: rtl/pirdsp_pkg.sv
// Shared definitions for PIRDSP datapath blocks: default widths and the
// accumulator FSM state encoding.
package pirdsp_pkg;

  localparam int XOR_WIDTH = 8;
  localparam int ACC_CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/config_shift_chain.sv
// Generic N-bit serial configuration register: shifts din into q[0] while
// enable is high, q[N-1] is the serial output. Clears to zero on reset.
module config_shift_chain #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         din,
  output logic [N-1:0] q,
  output logic         dout
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (enable) begin
      q <= {q[N-2:0], din};
    end
  end

  assign dout = q[N-1];

endmodule

// File: rtl/wide_xor_accumulator.sv
// Registers the wide XOR block's output and optionally XOR-folds it lane by
// lane over a configurable burst, presenting results on a valid/ready port.
module wide_xor_accumulator
  import pirdsp_pkg::*;
#(
  parameter int   WIDTH         = XOR_WIDTH,
  parameter int   CNT_W         = ACC_CNT_W,
  parameter logic input_freezed = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] XORIN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] XORACC,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             configuration_input,
  input  logic             configuration_enable,
  output logic             configuration_output
);

  function automatic logic [WIDTH-1:0] lane_fold(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    return a ^ b;
  endfunction

  logic [CNT_W:0]   cfg_q;
  logic [CNT_W-1:0] acclen;
  logic             accen;

  config_shift_chain #(.N(CNT_W + 1)) u_cfg (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (configuration_enable),
    .din     (configuration_input),
    .q       (cfg_q),
    .dout    (configuration_output)
  );

  assign acclen = cfg_q[CNT_W-1:0];
  assign accen  = cfg_q[CNT_W];

  acc_state_e       state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] xoracc_p1;
  logic             vld_p1;

  logic [WIDTH-1:0] xin_p0;
  logic [WIDTH-1:0] fold_p0;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_data;

  // Ready is gated by reset so no beat can be claimed while held in reset.
  assign in_ready = reset_n && !configuration_enable && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;
  assign xin_p0   = input_freezed ? '0 : XORIN;
  assign fold_p0  = lane_fold((state == ACCUM) ? acc : '0, xin_p0);

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    cnt_nx    = cnt;
    load      = 1'b0;
    load_data = xoracc_p1;
    if (configuration_enable) begin
      state_nx = IDLE;
      acc_nx   = '0;
      cnt_nx   = '0;
    end else if (accept) begin
      if (!accen) begin
        load      = 1'b1;
        load_data = xin_p0;
      end else if ((cnt == acclen) || flush) begin
        load      = 1'b1;
        load_data = fold_p0;
        state_nx  = IDLE;
        acc_nx    = '0;
        cnt_nx    = '0;
      end else begin
        state_nx = ACCUM;
        acc_nx   = fold_p0;
        cnt_nx   = cnt + 1'b1;
      end
    end else if (flush && accen && (state == ACCUM) && in_ready) begin
      // Early close with no beat: emit what has been folded so far.
      load      = 1'b1;
      load_data = acc;
      state_nx  = IDLE;
      acc_nx    = '0;
      cnt_nx    = '0;
    end
  end

  // Stage p1: accumulator state and output hold register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      xoracc_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      if (load) begin
        xoracc_p1 <= load_data;
        vld_p1    <= 1'b1;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign XORACC    = xoracc_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_wide_xor_accumulator.sv
// Scoreboard bench for wide_xor_accumulator: stimulus pushes hand-computed
// results, a negedge monitor pops and compares on every output transfer.
module tb_wide_xor_accumulator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] XORIN = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [7:0] XORACC;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       cfg_in = 1'b0;
  logic       cfg_en = 1'b0;
  logic       cfg_out;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic       cfg_hist[$];

  always #5 clk = ~clk;

  wide_xor_accumulator dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .XORIN                (XORIN),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .flush                (flush),
    .XORACC               (XORACC),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .configuration_input  (cfg_in),
    .configuration_enable (cfg_en),
    .configuration_output (cfg_out)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got XORACC=%0h, required no output", XORACC);
      end else begin
        chk("scoreboard_xoracc", XORACC, exp_q.pop_front());
      end
    end
  end

  // Present one request (beat and/or flush) and hold it until accepted.
  task automatic issue(input logic v, input logic [7:0] d, input logic fl);
    bit ok;
    ok = 0;
    in_valid = v;
    XORIN = d;
    flush = fl;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: in_ready=0, required 1 within 50 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    issue(1'b1, d, 1'b0);
  endtask

  // Shift {ACCEN, ACCLEN} in MSB first; the serial output must show the
  // bit that went in five shifts earlier.
  task automatic cfg_load(input logic [4:0] w);
    for (int i = 4; i >= 0; i--) begin
      cfg_en = 1'b1;
      cfg_in = w[i];
      cfg_hist.push_back(w[i]);
      @(negedge clk);
      chk("cfg_out_delay", cfg_out, cfg_hist.pop_front());
      chk("cfg_in_ready_low", in_ready, 0);
      @(posedge clk);
      #1;
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic reset_hist();
    cfg_hist.delete();
    for (int i = 0; i < 5; i++) cfg_hist.push_back(1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_hist();
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xoracc", XORACC, 8'h00);
    chk("rst_cfg_out", cfg_out, 0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Pass mode after reset: each beat appears one cycle later.
    exp_q.push_back(8'h3C);
    beat(8'h3C);
    exp_q.push_back(8'hA5);
    beat(8'hA5);
    @(negedge clk);
    chk("pass_valid_2nd", out_valid, 1);
    chk("pass_in_ready", in_ready, 1);
    @(negedge clk);
    chk("pass_valid_drop", out_valid, 0);

    // Accumulate, burst of 4.
    @(posedge clk); #1;
    cfg_load({1'b1, 4'd3});
    beat(8'h01);
    beat(8'h02);
    beat(8'h04);
    exp_q.push_back(8'h87);
    beat(8'h80);
    @(negedge clk);
    chk("acc_pulse", out_valid, 1);
    @(negedge clk);
    chk("acc_pulse_end", out_valid, 0);

    // Back-pressure in pass mode.
    @(posedge clk); #1;
    cfg_load({1'b0, 4'd0});
    out_ready = 1'b0;
    exp_q.push_back(8'h5A);
    beat(8'h5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_stable", XORACC, 8'h5A);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(8'h77);
    beat(8'h77);
    @(negedge clk);
    chk("bp_no_bubble_valid", out_valid, 1);
    chk("bp_no_bubble_data", XORACC, 8'h77);

    // Flush, burst length 8.
    @(posedge clk); #1;
    cfg_load({1'b1, 4'd7});
    beat(8'hFF);
    beat(8'h0F);
    exp_q.push_back(8'hF0);
    issue(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("flush_valid", out_valid, 1);
    @(posedge clk); #1;
    issue(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("flush_idle_none", out_valid, 0);
    @(negedge clk);
    chk("flush_idle_none2", out_valid, 0);
    @(posedge clk); #1;
    beat(8'h22);
    exp_q.push_back(8'h33);
    issue(1'b1, 8'h11, 1'b1);
    @(negedge clk);
    chk("flush_beat_valid", out_valid, 1);

    // Config mid-burst drops partial accumulation.
    @(posedge clk); #1;
    cfg_load({1'b1, 4'd2});
    beat(8'h01);
    beat(8'h02);
    cfg_load({1'b1, 4'd2});
    beat(8'h10);
    beat(8'h20);
    exp_q.push_back(8'h70);
    beat(8'h40);
    @(negedge clk);
    chk("cfg_drop_valid", out_valid, 1);

    // Async reset with a result pending.
    @(posedge clk); #1;
    out_ready = 1'b0;
    beat(8'h01);
    beat(8'h02);
    beat(8'h04);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", XORACC, 8'h07);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", XORACC, 8'h00);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_cfg_out", cfg_out, 0);
    reset_hist();
    #10 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cfg_load({1'b1, 4'd2});
    beat(8'h03);
    beat(8'h0C);
    exp_q.push_back(8'h3F);
    beat(8'h30);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wide_xor_accumulator.md
Name: wide_xor_accumulator

Overview:
- Downstream consumer of the wide XOR block's 8-bit XOROUT bus.
- Registers XOROUT and can optionally fold (XOR-accumulate) it lane-by-lane over a configurable burst of valid beats. This yields running parity or checksum results across consecutive results of the preceding XOR block.
- Result is presented on a valid/ready handshake with a 1-entry output hold register.
- Mode bits are loaded through the serial configuration chain, like the other PIRDSP blocks.

Parameters:
- WIDTH, 8, lane count; must equal the XOROUT width.
- CNT_W, 4, width of the burst-length config field and the beat counter.
- input_freezed, 1'b0; when 1, the XORIN input is forced to all zeros (tie-off for unused instances).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- XORIN  input  WIDTH  XOROUT bus from the upstream wide XOR block.
- in_valid  input  1  XORIN beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- flush  input  1  close the current accumulation early.
- XORACC  output  WIDTH  result data.
- out_valid  output  1  XORACC valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- configuration_input  input  1  serial config in.
- configuration_enable  input  1  shift enable for the config chain.
- configuration_output  output  1  serial config out.

Behaviour:
- Config chain: 1+CNT_W registers, shifted when configuration_enable=1.
  - ACCLEN[0] <= configuration_input; ACCLEN[i] <= ACCLEN[i-1]; ACCEN <= ACCLEN[CNT_W-1].
  - configuration_output = ACCEN.
  - All config registers reset to 0.
- Reset (async, reset_n=0) clears: acc=0, cnt=0, XORACC=0, out_valid=0, state=IDLE. in_ready is 0 while in reset.
- in_ready = !configuration_enable && (!out_valid || out_ready). This allows a single-cycle pass-through with no bubble.
- FSM states: IDLE (acc empty), ACCUM (acc holds ≥1 beat).
- ACCEN=0 (pass mode):
  - Each accepted beat loads XORACC=XORIN and sets out_valid next cycle (latency 1).
  - FSM stays IDLE; flush is ignored.
- ACCEN=1 (accumulate mode): burst length N = ACCLEN+1, range 1..2^CNT_W.
  - For an accepted beat, let v = acc ^ XORIN (acc is treated as 0 in IDLE).
  - If cnt==ACCLEN or flush=1: XORACC<=v, out_valid<=1, acc<=0, cnt<=0, go to IDLE.
  - Otherwise: acc<=v, cnt<=cnt+1, go to ACCUM.
  - flush=1 with no accepted beat, in ACCUM: XORACC<=acc, out_valid<=1 (if in_ready), acc<=0, cnt<=0, go to IDLE.
  - flush=1 with no accepted beat, in IDLE: no effect, so no empty result is ever emitted.
  - flush while out_valid && !out_ready: held off (in_ready=0). flush must be held by the source until in_ready=1.
- Output handshake:
  - out_valid clears on out_ready unless a new result loads in the same cycle.
  - XORACC is stable while out_valid && !out_ready.
- configuration_enable=1:
  - Forces in_ready=0.
  - Clears acc/cnt and sets state=IDLE, discarding any partial burst.
  - A pending XORACC/out_valid is kept and may still drain.
- The counter never wraps past ACCLEN.
- Changing ACCLEN mid-burst is only possible via configuration_enable, which clears the burst first.

Decomposition:
- Shared package pirdsp_pkg: WIDTH default, CNT_W, FSM state encoding (IDLE=0, ACCUM=1).
- One natural sub-module: config_shift_chain (generic N-bit serial config register with enable, reset value 0), reusable by other PIRDSP blocks.
- Accumulator, counter, FSM and output register stay in the top module.

Test Plan:
- Reset then pass mode (ACCEN=0): beats 0x3C, 0xA5 with out_ready=1 -> XORACC=0x3C then 0xA5, each one cycle after acceptance, out_valid high for 2 cycles, in_ready held 1.
- Accumulate with ACCLEN=3: beats 0x01, 0x02, 0x04, 0x80 -> single result 0x87 with a one-cycle out_valid pulse after the 4th beat; no output for beats 1-3.
- Back-pressure: result pending with out_ready=0 for 5 cycles -> in_ready=0 and XORACC stable. Then out_ready=1 together with in_valid in ACCEN=0 -> new beat accepted the same cycle, next value appears with no bubble.
- Flush, ACCLEN=7: beats 0xFF, 0x0F, then flush with no beat -> XORACC=0xF0. flush in IDLE -> no out_valid. flush together with beat 0x11 after one beat 0x22 -> XORACC=0x33.
- Config: shift 5 bits serially to set ACCEN=1, ACCLEN=2 -> configuration_output reproduces the bits delayed by 5 cycles. Asserting configuration_enable mid-burst drops the partial acc: next 3 beats 0x10, 0x20, 0x40 give 0x70.
- Async reset asserted mid-burst with out_valid=1 -> out_valid, XORACC, acc and cnt go to 0 immediately, without a clock edge; config registers read back 0.
